reg_bank: RTL
=============

# reg_bank

Parametrised successor to the 16x8 register file: a register bank of 2**AW words of DW bits with NRD combinational read ports, one write port and an in-bank move (copy) port. It adds a hardware clear sweep on reset and on request, an optional write-to-read bypass, and a write/move conflict flag. It sits between the decoder/ALU writeback path and the ALU operand muxes, and is a drop-in for the core's register storage.

## Interface
- DW, 8, data width in bits
- AW, 4, address width; depth = 2**AW
- NRD, 2, number of read ports
- BYPASS, 0, 1 = read ports forward accepted same-cycle write data
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  write enable
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- mv_en  in  1  move enable: core[mv_dst] <= core[mv_src]
- mv_src  in  AW  move source address
- mv_dst  in  AW  move destination address
- clr_req  in  1  start a clear sweep (single-cycle pulse)
- rd_addr  in  NRD*AW  packed read addresses; port i = bits [i*AW +: AW]
- rd_data  out  NRD*DW  packed read data; port i = bits [i*DW +: DW]
- busy  out  1  clear sweep in progress; writes, moves and clr_req are ignored
- conflict  out  1  registered one-cycle pulse: the previous cycle accepted a write and a move to the same address

## Operation
- FSM states: IDLE, CLEAR. Sweep pointer clr_ptr is AW bits wide.
- rst_n low at a clock edge: state <= CLEAR, clr_ptr <= 0, conflict <= 0. The array is not reset directly.
- CLEAR with rst_n high, each edge: core[clr_ptr] <= 0, then clr_ptr increments.
  - When clr_ptr == 2**AW-1, state <= IDLE in the same edge.
- busy = (state == CLEAR), decoded combinationally.
  - busy is 1 during reset and for exactly 2**AW cycles after rst_n rises.
- IDLE with clr_req = 1: state <= CLEAR, clr_ptr <= 0. wr_en and mv_en in that same cycle are still honoured.
- While busy: wr_en, mv_en and clr_req are dropped with no side effects. Reads stay live and return the partially cleared array.
- Write (IDLE, wr_en): core[wr_addr] <= wr_data.
- Move (IDLE, mv_en): core[mv_dst] <= core[mv_src]. The source value is the pre-edge value.
  - If wr_addr == mv_src in the same cycle, the move copies the old value.
- Write and move in the same cycle with wr_addr != mv_dst: both take effect.
- Write and move with wr_addr == mv_dst: the write wins and the move is dropped. conflict = 1 on the next cycle only.
- mv_src == mv_dst: no change, no conflict.
- Reads: rd_data[i] = core[rd_addr[i]], combinational.
  - BYPASS=1: if wr_en is accepted (IDLE) and rd_addr[i] == wr_addr, rd_data[i] = wr_data.
  - Moves are never bypassed.
- Before the first sweep completes, uncleared words read X in simulation.

## Timing
- Write and move latency: the value is visible on read ports in the cycle after the edge. With BYPASS=1, a write is visible in the same cycle.
- Clear sweep: 2**AW cycles. Word k becomes 0 at edge k+1 after sweep start.
- Reset mid-sweep restarts the sweep from pointer 0.
- conflict: registered, 1-cycle latency, reset value 0. busy reset value 1.
- No combinational path from wr_en, mv_en or clr_req to busy.

## Structure
- Package reg_bank_pkg holds typedef enum logic [0:0] {IDLE, CLEAR} rb_state_t and the localparam defaults for DW and AW.
- Single module, no sub-module. The sweep counter and FSM are small enough to stay inline.
- Storage: logic [DW-1:0] core [2**AW]. All array writes go in one always_ff, with sweep > write > move priority per address.

## Test plan
- Reset release, DW=8, AW=4: busy stays 1 for 16 cycles then drops. Every address reads 0x00. A wr_en issued during busy is dropped (addr 3 still reads 0x00).
- Write then move: write 0xA5 to r2, then move r2->r7. r7 reads 0xA5 one cycle after the move, and r2 is unchanged.
- Same-cycle write r4 = 0x3C and move r1->r4 (r1 = 0x11): r4 reads 0x3C and conflict is 1 for exactly one cycle.
- Same-cycle write r5 = 0x99 and move r5->r6 (old r5 = 0x22): r6 reads 0x22 and r5 reads 0x99.
- BYPASS=1: write r9 = 0x5A while rd_addr port 1 = 9. Port 1 reads 0x5A in the same cycle. With BYPASS=0 it reads the old value.
- clr_req with r2 = 0xFF, then rst_n low at sweep cycle 5: busy stays 1 and the sweep restarts. Completion occurs 16 cycles after rst_n rises, and r2 = 0x00.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared types and default geometry for the reg_bank register file.
//   rb_state_t  - clear-sweep FSM state (IDLE / CLEAR)
//   DefaultDw   - default data width
//   DefaultAw   - default address width (depth = 2**AW)
package reg_bank_pkg;

    typedef enum logic [0:0] {
        IDLE,
        CLEAR
    } rb_state_t;

    localparam int unsigned DefaultDw = 8;
    localparam int unsigned DefaultAw = 4;

endpackage

// File: rtl/reg_bank.sv
// reg_bank: 2**AW x DW register bank with NRD combinational read ports, one write port,
// an in-bank move (copy) port, a hardware clear sweep and a write/move conflict flag.
// Ports:
//   clk, rst_n                  - clock, synchronous active-low reset
//   wr_en, wr_addr, wr_data     - write port
//   mv_en, mv_src, mv_dst       - move port: core[mv_dst] <= core[mv_src]
//   clr_req                     - start a clear sweep
//   rd_addr / rd_data           - packed read ports, port i at [i*AW +: AW] / [i*DW +: DW]
//   busy                        - clear sweep in progress; writes, moves, clr_req ignored
//   conflict                    - one-cycle pulse: last cycle's write and move hit one address
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int unsigned DW     = DefaultDw,
    parameter int unsigned AW     = DefaultAw,
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              mv_en,
    input  logic [AW-1:0]     mv_src,
    input  logic [AW-1:0]     mv_dst,
    input  logic              clr_req,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic              busy,
    output logic              conflict
);

    localparam int unsigned Depth = 2 ** AW;

    logic [DW-1:0] core [Depth];

    rb_state_t     state_q;
    logic [AW-1:0] clr_ptr_q;
    logic          conflict_q;

    logic wr_ok;
    logic mv_req;
    logic mv_hit;
    logic mv_ok;

    assign busy     = (state_q == CLEAR);
    assign conflict = conflict_q;

    assign wr_ok  = wr_en & ~busy;
    // A self-move changes nothing, so it is treated as no move at all (and cannot conflict).
    assign mv_req = mv_en & ~busy & (mv_src != mv_dst);
    assign mv_hit = wr_ok & mv_req & (wr_addr == mv_dst);
    assign mv_ok  = mv_req & ~mv_hit;

    // Sweep FSM and conflict flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= mv_hit;
            unique case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_q   <= CLEAR;
                        clr_ptr_q <= '0;
                    end
                end
                CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + 1'b1;
                    if (&clr_ptr_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    // Storage. Sweep and write/move are mutually exclusive through busy; a move whose
    // destination collides with the write has already been suppressed via mv_hit.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (busy) begin
                core[clr_ptr_q] <= '0;
            end else begin
                if (wr_ok) begin
                    core[wr_addr] <= wr_data;
                end
                if (mv_ok) begin
                    core[mv_dst] <= core[mv_src];
                end
            end
        end
    end

    // Read ports; optional forwarding of the accepted write (moves are never forwarded).
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_data[i*DW +: DW] = core[rd_addr[i*AW +: AW]];
            if ((BYPASS != 0) && wr_ok && (rd_addr[i*AW +: AW] == wr_addr)) begin
                rd_data[i*DW +: DW] = wr_data;
            end
        end
    end

endmodule
